// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline register chain:
// occupancy counter sizing and the square-root datapath stage patterns.
package pipe_reg_pkg;

    localparam int SQRT_STAGE_WIDTH = 4;
    localparam logic [SQRT_STAGE_WIDTH-1:0] SQRT_RESET_VAL = 4'b0010;
    localparam logic [SQRT_STAGE_WIDTH-1:0] SQRT_SET_VAL   = 4'b1111;

    // Counter must hold 0..DEPTH+1 so the skid-buffer build fits too.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: data register plus valid bit.
// Reset wins over set, and set wins over a ready-qualified load.
module pipe_stage_cell
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q_data  <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (set) begin
            q_data  <= SET_VAL;
            q_valid <= 1'b0;
        end else if (load) begin
            q_data  <= d_data;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic DEPTH-stage register chain with valid/ready handshaking.
// Define PIPE_STAGE_REG_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_reg
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          set,
    input  logic                          enable,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OW = occ_width(DEPTH);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];
    logic [DEPTH-1:0] stage_ready;
    logic [WIDTH-1:0] src_data;
    logic             src_valid;
    logic             in_xfer;
    logic             out_xfer;

    // Ready ripples back from out_ready; a stage accepts when empty or draining.
    always_comb begin
        logic chain;
        stage_ready = '0;
        chain       = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain          = enable & (~stage_valid[i] | chain);
            stage_ready[i] = chain;
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign in_ready  = ~skid_valid & enable;
    assign src_valid = skid_valid | in_valid;
    assign src_data  = skid_valid ? skid_data : in_data;

    // A word accepted while stage 0 is blocked parks here and drains first.
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_data  <= RESET_VAL;
        end else if (set) begin
            skid_valid <= 1'b0;
            skid_data  <= SET_VAL;
        end else if (skid_valid && stage_ready[0]) begin
            skid_valid <= 1'b0;
        end else if (in_xfer && !stage_ready[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready  = stage_ready[0];
    assign src_valid = in_valid;
    assign src_data  = in_data;
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_data;
        logic             d_valid;

        if (i == 0) begin : g_head
            assign d_data  = src_data;
            assign d_valid = src_valid;
        end else begin : g_body
            assign d_data  = stage_data[i-1];
            assign d_valid = stage_valid[i-1];
        end

        pipe_stage_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL),
            .SET_VAL   (SET_VAL)
        ) u_cell (
            .clock   (clock),
            .reset   (reset),
            .set     (set),
            .load    (stage_ready[i]),
            .d_data  (d_data),
            .d_valid (d_valid),
            .q_data  (stage_data[i]),
            .q_valid (stage_valid[i])
        );
    end

    assign out_data  = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready & enable;

    // Simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock) begin
        if (reset || set) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OW'(1);
        end else if (out_xfer && !in_xfer) begin
            occupancy <= occupancy - OW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Table-driven bench for pipe_stage_reg (WIDTH=4, DEPTH=3) with a data scoreboard.
// Selects the skid-buffer vector set when PIPE_STAGE_REG_SKID_EN is defined.
module tb_pipe_stage_reg;

    logic       clock;
    logic       reset;
    logic       set;
    logic       enable;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] occupancy;

    typedef struct {
        logic       rst;
        logic       set;
        logic       en;
        logic       iv;
        logic [3:0] din;
        logic       ordy;
        logic       chk;
        logic       e_ir;
        logic       e_ov;
        logic [2:0] e_occ;
        logic       lit_en;
        logic [3:0] lit;
    } vec_t;

    vec_t       vecs [$];
    logic [3:0] sb_q [$];
    int         checks = 0;
    int         errors = 0;

    pipe_stage_reg #(
        .WIDTH     (4),
        .DEPTH     (3),
        .RESET_VAL (4'b0010),
        .SET_VAL   (4'b1111)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .set       (set),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input logic rst, input logic st, input logic en, input logic iv,
                          input logic [3:0] din, input logic ordy, input logic chk,
                          input logic e_ir, input logic e_ov, input logic [2:0] e_occ,
                          input logic lit_en, input logic [3:0] lit);
        vec_t v;
        v.rst = rst; v.set = st; v.en = en; v.iv = iv; v.din = din; v.ordy = ordy;
        v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ;
        v.lit_en = lit_en; v.lit = lit;
        vecs.push_back(v);
    endtask

    task automatic checkEq(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        set       = v.set;
        enable    = v.en;
        in_valid  = v.iv;
        in_data   = v.din;
        out_ready = v.ordy;
    endtask

    // Compares the pre-edge outputs, then advances the scoreboard as the edge will.
    task automatic checkOutput(input int idx, input vec_t v);
        if (v.chk) begin
            checkEq($sformatf("v%0d in_ready", idx), {3'b0, in_ready}, {3'b0, v.e_ir});
            checkEq($sformatf("v%0d out_valid", idx), {3'b0, out_valid}, {3'b0, v.e_ov});
            checkEq($sformatf("v%0d occupancy", idx), {1'b0, occupancy}, {1'b0, v.e_occ});
            if (v.lit_en)
                checkEq($sformatf("v%0d out_data", idx), out_data, v.lit);
            if (v.e_ov) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL v%0d scoreboard: got empty queue, expected a word", idx);
                end else begin
                    checkEq($sformatf("v%0d out_data", idx), out_data, sb_q[0]);
                end
            end
        end
        if (v.rst || v.set) begin
            sb_q.delete();
        end else begin
            if (v.e_ov && v.ordy && v.en && sb_q.size() > 0)
                void'(sb_q.pop_front());
            if (v.e_ir && v.iv)
                sb_q.push_back(v.din);
        end
    endtask

    initial begin
        int  lat;
        bit  found;

        // rst set en iv din ordy | chk ir ov occ | lit_en lit
        addVec(1, 0, 1, 0, 4'h0, 1,  0, 0, 0, 0,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 0, 0,  1, 4'h2);
        addVec(0, 0, 1, 1, 4'h1, 1,  1, 1, 0, 0,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'h2, 1,  1, 1, 0, 1,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'h3, 1,  1, 1, 0, 2,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'h4, 1,  1, 1, 1, 3,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 1, 3,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 1, 2,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 1, 1,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 0,  1, 1, 0, 0,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'hA, 0,  1, 1, 0, 0,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'hB, 0,  1, 1, 0, 1,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'hC, 0,  1, 1, 0, 2,  0, 4'h0);
`ifdef PIPE_STAGE_REG_SKID_EN
        addVec(0, 0, 1, 1, 4'hD, 0,  1, 1, 1, 3,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'hE, 0,  1, 0, 1, 4,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'hE, 1,  1, 0, 1, 4,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 1, 3,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 1, 2,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 1, 1,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 0, 0,  0, 4'h0);
        addVec(0, 1, 1, 0, 4'h0, 1,  1, 1, 0, 0,  0, 4'h0);
`else
        addVec(0, 0, 1, 1, 4'hD, 0,  1, 0, 1, 3,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'hD, 1,  1, 1, 1, 3,  0, 4'h0);
        addVec(0, 0, 0, 0, 4'h0, 1,  1, 0, 1, 3,  0, 4'h0);
        addVec(0, 0, 0, 0, 4'h0, 1,  1, 0, 1, 3,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 1, 3,  0, 4'h0);
        addVec(0, 0, 1, 1, 4'hE, 1,  1, 1, 1, 2,  0, 4'h0);
        addVec(0, 1, 1, 0, 4'h0, 1,  1, 1, 1, 2,  0, 4'h0);
`endif
        addVec(0, 0, 1, 0, 4'h0, 1,  1, 1, 0, 0,  1, 4'hF);
        addVec(1, 1, 1, 0, 4'h0, 1,  1, 1, 0, 0,  0, 4'h0);
        addVec(0, 0, 1, 0, 4'h0, 0,  1, 1, 0, 0,  1, 4'h2);

        foreach (vecs[i]) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #2;
            checkOutput(i, vecs[i]);
        end

        // Single word into an empty chain must surface exactly DEPTH edges later.
        @(negedge clock);
        reset = 1'b0; set = 1'b0; enable = 1'b1;
        in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
        #2;
        checkEq("latency accept", {3'b0, in_ready}, 4'h1);
        lat   = 0;
        found = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
            in_data  = 4'h0;
            #2;
            if (out_valid) begin
                found = 1'b1;
                lat   = k;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL latency wait: got no out_valid in 10 cycles, expected 3");
        end else begin
            checkEq("latency cycles", lat[3:0], 4'd3);
            checkEq("latency data", out_data, 4'h7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register chain for the iterative arithmetic datapaths (square-root and similar stage-to-stage transfers).
- Holds DEPTH stages of WIDTH-bit data, each with a valid bit and valid/ready handshaking, plus a per-bit programmable reset pattern and a synchronous set pattern.
- Replaces the fixed-width, hand-instantiated per-bit stage registers between datapath stages.

Parameters:
- WIDTH, 4: data width in bits (>=1).
- DEPTH, 1: number of register stages (>=1).
- RESET_VAL, {WIDTH{1'b0}}: data value loaded into every stage on reset.
- SET_VAL, {WIDTH{1'b1}}: data value loaded into every stage on set.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- set  input  1  synchronous set; loads SET_VAL into every stage and clears valids.
- enable  input  1  global advance enable; low freezes all state.
- in_data  input  WIDTH  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  WIDTH  data of the last stage.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data.
- occupancy  output  $clog2(DEPTH+2)  count of valid entries held.

Behaviour:
- Clocking and reset:
  - All state updates on the rising clock edge.
  - Priority: reset > set > enable.
- Reset (sampled high at the edge):
  - Every stage data = RESET_VAL, every valid = 0, occupancy = 0.
  - Outputs after the edge: out_data = RESET_VAL, out_valid = 0, in_ready = 1 while enable is high.
- Set (with reset low):
  - Every stage data = SET_VAL, valids = 0, occupancy = 0.
  - In-flight data is discarded.
- enable low (reset and set low):
  - No register changes.
  - in_ready = 0.
  - out_valid and out_data hold their values.
  - A downstream handshake is not counted.
- Per-stage handshake (stage i, last stage i = DEPTH-1):
  - ready_i = enable & (!valid_i | ready_{i+1}), where ready_DEPTH = out_ready.
  - On an edge with ready_i high, stage i loads data and valid from stage i-1 (stage 0 loads in_data and in_valid).
  - Bubbles collapse. A full stage may be written in the same cycle it drains.
- Transfers:
  - in_ready = ready_0.
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready & enable.
- Latency and throughput:
  - An accepted word appears on out_data exactly DEPTH cycles later when the chain is empty and out_ready stays high.
  - Throughput is 1 word per cycle.
- Stage data on a non-valid load:
  - A stage loading valid = 0 still captures the incoming data value. This means data is don't-care when invalid.
  - Exception: directly after reset or set, all stages hold RESET_VAL or SET_VAL exactly.
- occupancy:
  - +1 on an input transfer, -1 on an output transfer, unchanged when both occur.
  - Never exceeds the capacity (DEPTH, or DEPTH+1 with the skid buffer).
- Boundaries:
  - Full chain with out_ready = 0: in_ready = 0 in the same cycle.
  - Full chain with out_ready = 1: push and pop in the same cycle, occupancy unchanged.
  - Empty chain: out_valid = 0, and out_data shows the last stage's stored value.
- Reset or set mid-stream drops all words. No output transfer is reported in that cycle.

Optional Feature:
- Macro: PIPE_STAGE_REG_SKID_EN.
- Defined:
  - A one-entry skid buffer is inserted ahead of stage 0.
  - in_ready becomes a registered signal, equal to !skid_valid & enable.
  - This breaks the combinational ready path from out_ready.
  - When stage 0 cannot accept, an accepted word is parked in the skid buffer. It enters stage 0 with priority on the next cycle in which ready_0 is high.
  - Capacity is DEPTH+1.
  - Latency is unchanged when the skid buffer is empty.
  - reset and set clear the skid buffer.
- Undefined: behaviour exactly as above, with capacity DEPTH and a combinational in_ready.

Decomposition:
- Shared package pipe_reg_pkg:
  - function occ_width(depth), returning $clog2(depth+2).
  - Default RESET_VAL and SET_VAL localparams for the square-root stage widths.
- Sub-module pipe_stage_cell: one data register and valid bit with reset, set and load-on-ready. It is generated DEPTH times.
- The skid buffer stays inline under the macro.

Test Plan (WIDTH=4, DEPTH=3, RESET_VAL=4'b0010, SET_VAL=4'b1111):
- Reset high for one cycle -> out_data=4'b0010, out_valid=0, occupancy=0, in_ready=1.
- Stream 4'h1, 4'h2, 4'h3, 4'h4 on consecutive cycles with out_ready=1 -> 4'h1 on out_data at cycle 3, then one word per cycle, occupancy never exceeds 3.
- out_ready=0 and push 4'hA, 4'hB, 4'hC, 4'hD -> three accepted, in_ready=0 on the fourth, occupancy=3. Raise out_ready -> 4'hA, 4'hB, 4'hC out in order; 4'hD is accepted the same cycle 4'hA leaves.
- Full chain, enable low for 2 cycles with out_ready=1 -> no output transfer, data and occupancy unchanged. Enable high -> draining resumes.
- set pulse with 2 words in flight -> next cycle out_data=4'hF, out_valid=0, occupancy=0. reset and set both high -> out_data=4'b0010.
- With PIPE_STAGE_REG_SKID_EN, out_ready=0, push 5 words -> 4 accepted, occupancy=4, in_ready deasserts one cycle after the skid buffer fills. Drain -> all 4 words in order.
